uniform_sampler_compact: RTL and testbench
==========================================

Name: uniform_sampler_compact

Overview:
Parametrised successor to the lane-parallel uniform rejection sampler. Splits each wide random word into CAND_BITS candidates and rejects any candidate >= q. Accepted values are compacted in order into a buffer, and the block emits dense OUT_LANES-wide coefficient beats under valid/ready, stopping after exactly N_COEFF coefficients per polynomial. Sits between the XOF/random source and the polynomial RAM writer, replacing the sparse per-lane valid/retry-mask interface.

Parameters:
IN_BITS, 192, random word width; must be a multiple of CAND_BITS
CAND_BITS, 12, candidate/coefficient width
Q_BITS, 16, modulus port width; only the low CAND_BITS bits are compared when Q_BITS > CAND_BITS
OUT_LANES, 4, coefficients per output beat
BUF_DEPTH, 32, compaction buffer entries; must be >= 2*CANDS (CANDS = IN_BITS/CAND_BITS)
N_COEFF, 256, coefficients per polynomial

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a new polynomial; latches q
q  in  Q_BITS  modulus; sampled only on accepted start
random_valid  in  1  random word valid
random_in  in  IN_BITS  random word; candidate i = bits [i*CAND_BITS +: CAND_BITS], i=0 is first in order
random_ready  out  1  sampler can take a word
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_coeffs  out  OUT_LANES*CAND_BITS  lane 0 = oldest coefficient
out_mask  out  OUT_LANES  valid lanes in beat; all-ones except possibly the final beat
poly_done  out  1  one-cycle pulse after the final beat handshake
busy  out  1  state != IDLE
reject_cnt  out  16  rejected candidates this polynomial (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; buffer empty; counters 0; stage register invalid.
- FSM:
  - IDLE -> SAMPLE on start. Latch q; clear counters.
  - SAMPLE -> DRAIN when accepted_total == N_COEFF.
  - DRAIN -> DONE when the buffer is empty and the last beat has handshaken.
  - DONE -> IDLE after one cycle, with poly_done=1 in DONE.
  - start outside IDLE is ignored.
- Input handshake occurs when random_valid && random_ready.
- random_ready = (state==SAMPLE) && (occupancy + (stage_valid ? CANDS : 0) + CANDS <= BUF_DEPTH). This is conservative; no accepted value is ever dropped for lack of space.
- Pipeline:
  - Handshake edge t loads the stage register with the word and per-candidate accept flags (cand < q_latched).
  - Edge t+1 writes accepted candidates, in index order, at the buffer tail.
  - out_valid can rise in the cycle after edge t+1, so latency is 2 cycles.
- Quota: at most N_COEFF - accepted_total candidates are written per word. Surplus accepted candidates are discarded, including those in any word already in the stage register. Discarded surplus is not counted as rejected.
- Output:
  - out_valid = (occupancy >= OUT_LANES) || (state==DRAIN && occupancy > 0).
  - On out_valid && out_ready, pop min(OUT_LANES, occupancy) entries; out_mask marks popped lanes.
  - out_coeffs and out_mask are held stable while out_valid && !out_ready.
- Simultaneous push and pop in one cycle are both honoured; occupancy updates by the net amount.
- q == 0: every candidate is rejected; the block stays in SAMPLE indefinitely until rst.
- Buffer is a circular array with head/tail wrap modulo BUF_DEPTH. Occupancy never exceeds BUF_DEPTH.
- rst mid-operation flushes the buffer, the stage register and the counters, and returns to IDLE next edge.

Optional Feature:
UNIFORM_REJECT_STATS_EN.
- Defined: reject_cnt increments by the number of rejected candidates per stage-register word. It saturates at 0xFFFF and clears on start.
- Undefined: reject_cnt is tied to 0 and no counter logic is built.

Test Plan:
- q=3329, 16 words of all-zero candidates -> 64 beats of zeros, out_mask=4'hF each; poly_done pulses once; random_ready is low after the 16th word; reject_cnt=0.
- q=3329, candidates alternating 0xD00/0xD01 -> 8 accepts per word, coefficient order 0xD00 only; reject_cnt=8 per word (stats on); 32 words total.
- q=3329, all candidates 0xFFF for 10 words -> out_valid never rises; reject_cnt=160; state stays SAMPLE.
- Backpressure: out_ready=0 with all-accept words -> random_ready drops once occupancy=16 with stage valid. Releasing out_ready yields the 256-coefficient sequence intact and in order.
- Overshoot: 15 all-accept words (240 coefficients), then one word with 16 accepts -> only its first 16 used (exactly 256 total). Repeat with N_COEFF=250 -> the final beat has out_mask=4'b0011 and poly_done follows it.
- rst asserted mid-SAMPLE with 10 entries buffered -> next cycle out_valid=0, busy=0. A new start runs a clean 256-coefficient polynomial.

Source files
------------

// File: rtl/uniform_sampler_compact.sv
// Rejection sampler that compacts accepted candidates into dense output beats.
// Optional reject statistics counter: define UNIFORM_REJECT_STATS_EN.
module uniform_sampler_compact #(
  parameter int IN_BITS   = 192,
  parameter int CAND_BITS = 12,
  parameter int Q_BITS    = 16,
  parameter int OUT_LANES = 4,
  parameter int BUF_DEPTH = 32,
  parameter int N_COEFF   = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [Q_BITS-1:0]              q,
  input  logic                           random_valid,
  input  logic [IN_BITS-1:0]             random_in,
  output logic                           random_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_LANES*CAND_BITS-1:0] out_coeffs,
  output logic [OUT_LANES-1:0]           out_mask,
  output logic                           poly_done,
  output logic                           busy,
  output logic [15:0]                    reject_cnt
);

  localparam int CANDS = IN_BITS / CAND_BITS;
  localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW    = $clog2(BUF_DEPTH + CANDS + N_COEFF + 1) + 1;
  localparam int QL    = (Q_BITS > CAND_BITS) ? Q_BITS : CAND_BITS;
  localparam logic [QL-1:0] QMASK = QL'((64'd1 << CAND_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [QL-1:0] q_lat_q;

  logic                 stg_vld_q;
  logic [IN_BITS-1:0]   stg_data_q;
  logic [CANDS-1:0]     stg_acc_q;

  logic [CAND_BITS-1:0] mem_q [BUF_DEPTH];

  logic [QL-1:0]        q_cmp;
  logic [CANDS-1:0]     acc_in;
  logic                 in_fire;
  logic [CW-1:0]        quota;
  logic [CW-1:0]        n_wr;
  logic [CW-1:0]        pop_n;
  logic [CANDS-1:0]     wr_en;
  logic [PW-1:0]        wr_idx [CANDS];
  logic [CAND_BITS-1:0] cand [CANDS];

  function automatic logic [PW-1:0] wrap_idx(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    if (r >= CW'(BUF_DEPTH)) r = r - CW'(BUF_DEPTH);
    return r[PW-1:0];
  endfunction

  // Only the low CAND_BITS of the latched modulus take part in the compare
  assign q_cmp = q_lat_q & QMASK;

  always_comb begin
    for (int i = 0; i < CANDS; i++) begin
      acc_in[i] = QL'(random_in[i*CAND_BITS +: CAND_BITS]) < q_cmp;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign poly_done = (state_q == S_DONE);
  assign quota     = CW'(N_COEFF) - acc_q;

  // Compact accepted candidates in index order, clipped to the remaining quota
  always_comb begin
    wr_en = '0;
    n_wr  = '0;
    for (int i = 0; i < CANDS; i++) begin
      wr_idx[i] = '0;
      cand[i]   = stg_data_q[i*CAND_BITS +: CAND_BITS];
      if (stg_vld_q && stg_acc_q[i] && (n_wr < quota)) begin
        wr_en[i]  = 1'b1;
        wr_idx[i] = wrap_idx(CW'(tail_q) + n_wr);
        n_wr      = n_wr + CW'(1);
      end
    end
  end

  always_comb begin
    out_valid  = (occ_q >= CW'(OUT_LANES)) ||
                 ((state_q == S_DRAIN) && (occ_q != '0));
    out_coeffs = '0;
    out_mask   = '0;
    for (int k = 0; k < OUT_LANES; k++) begin
      if (out_valid) begin
        out_coeffs[k*CAND_BITS +: CAND_BITS] =
          mem_q[wrap_idx(CW'(head_q) + CW'(k))];
        out_mask[k] = (CW'(k) < occ_q);
      end
    end
    pop_n = '0;
    if (out_valid && out_ready) begin
      pop_n = (occ_q >= CW'(OUT_LANES)) ? CW'(OUT_LANES) : occ_q;
    end
    random_ready = (state_q == S_SAMPLE) &&
                   ((occ_q + (stg_vld_q ? CW'(CANDS) : '0) + CW'(CANDS))
                    <= CW'(BUF_DEPTH));
  end

  assign in_fire = random_valid && random_ready;

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q + n_wr - pop_n;
    head_d  = wrap_idx(CW'(head_q) + pop_n);
    tail_d  = wrap_idx(CW'(tail_q) + n_wr);
    acc_d   = acc_q + n_wr;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          acc_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (acc_q == CW'(N_COEFF)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (occ_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      occ_q     <= '0;
      acc_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      q_lat_q   <= '0;
      stg_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      acc_q     <= acc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      stg_vld_q <= in_fire;
      if ((state_q == S_IDLE) && start) q_lat_q <= QL'(q);
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      stg_data_q <= random_in;
      stg_acc_q  <= acc_in;
    end
    for (int i = 0; i < CANDS; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= cand[i];
    end
  end

`ifdef UNIFORM_REJECT_STATS_EN
  logic [15:0]   rej_q, rej_d;
  logic [16:0]   rej_sum;
  logic [CW-1:0] n_rej;

  always_comb begin
    n_rej = '0;
    for (int i = 0; i < CANDS; i++) begin
      if (stg_vld_q && !stg_acc_q[i]) n_rej = n_rej + CW'(1);
    end
    rej_sum = {1'b0, rej_q} + 17'(n_rej);
    rej_d   = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
    if ((state_q == S_IDLE) && start) rej_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rej_q <= '0;
    else     rej_q <= rej_d;
  end

  assign reject_cnt = rej_q;
`else
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_uniform_sampler_compact.sv
// Scoreboard bench for uniform_sampler_compact (N_COEFF=256 and 250 instances).
// A software model queues expected coefficients; beats are compared on handshake.
module tb_uniform_sampler_compact;

  localparam int CB = 12;
  localparam int NL = 4;
  localparam int IB = 192;
  localparam int NC = IB / CB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, sel, random_valid, out_ready;
  logic [15:0]   q;
  logic [IB-1:0] random_in;

  logic          a_rready, a_valid, a_done, a_busy;
  logic [NL*CB-1:0] a_coeffs;
  logic [NL-1:0] a_mask;
  logic [15:0]   a_rej;
  logic          b_rready, b_valid, b_done, b_busy;
  logic [NL*CB-1:0] b_coeffs;
  logic [NL-1:0] b_mask;
  logic [15:0]   b_rej;

  uniform_sampler_compact #(.N_COEFF(256)) u_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .q(q),
    .random_valid(random_valid & ~sel), .random_in(random_in),
    .random_ready(a_rready), .out_valid(a_valid),
    .out_ready(out_ready & ~sel), .out_coeffs(a_coeffs),
    .out_mask(a_mask), .poly_done(a_done), .busy(a_busy),
    .reject_cnt(a_rej)
  );

  uniform_sampler_compact #(.N_COEFF(250)) u_b (
    .clk(clk), .rst(rst), .start(start & sel), .q(q),
    .random_valid(random_valid & sel), .random_in(random_in),
    .random_ready(b_rready), .out_valid(b_valid),
    .out_ready(out_ready & sel), .out_coeffs(b_coeffs),
    .out_mask(b_mask), .poly_done(b_done), .busy(b_busy),
    .reject_cnt(b_rej)
  );

  logic          o_rready, o_valid, o_done, o_busy;
  logic [NL*CB-1:0] o_coeffs;
  logic [NL-1:0] o_mask;
  logic [15:0]   o_rej;

  assign o_rready = sel ? b_rready : a_rready;
  assign o_valid  = sel ? b_valid  : a_valid;
  assign o_done   = sel ? b_done   : a_done;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_coeffs = sel ? b_coeffs : a_coeffs;
  assign o_mask   = sel ? b_mask   : a_mask;
  assign o_rej    = sel ? b_rej    : a_rej;

  int errs = 0;
  int checks = 0;
  logic [CB-1:0] sb [$];
  int pushed, emitted, n_exp, done_cnt, exp_rej, mon_m;
  logic valid_seen;
  logic [NL-1:0] last_mask, mon_msk;
  logic [63:0] mon_got, mon_exp;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rej_exp();
`ifdef UNIFORM_REJECT_STATS_EN
    return exp_rej;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (o_valid) valid_seen = 1'b1;
    if (o_done) done_cnt++;
    if (o_valid && out_ready) begin
      mon_m = n_exp - emitted;
      if (mon_m > NL) mon_m = NL;
      if (mon_m < 0) mon_m = 0;
      mon_msk = 4'((1 << mon_m) - 1);
      mon_got = '0;
      mon_exp = '0;
      for (int k = 0; k < NL; k++) begin
        if (k < mon_m) begin
          mon_got[k*CB +: CB] = o_coeffs[k*CB +: CB];
          if (sb.size() > 0) mon_exp[k*CB +: CB] = sb.pop_front();
        end
      end
      check("mask", 64'(o_mask), 64'(mon_msk));
      check("beat", mon_got, mon_exp);
      emitted += mon_m;
      last_mask = o_mask;
    end
  end

  function automatic logic [IB-1:0] mk_word(input int mode);
    logic [IB-1:0] w;
    logic [CB-1:0] c;
    w = '0;
    for (int i = 0; i < NC; i++) begin
      case (mode)
        0: c = 12'h000;
        1: c = (i % 2 == 0) ? 12'hD00 : 12'hD01;
        2: c = 12'hFFF;
        3: c = CB'($urandom_range(0, 3328));
        4: c = CB'($urandom_range(0, 4095));
        default: c = (i < 10) ? CB'($urandom_range(0, 3328)) : 12'hFFF;
      endcase
      w[i*CB +: CB] = c;
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_poly(input logic [15:0] qv);
    q = qv;
    start = 1'b1;
    sb.delete();
    pushed = 0;
    emitted = 0;
    exp_rej = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [IB-1:0] w);
    int t;
    logic [CB-1:0] c;
    t = 0;
    random_valid = 1'b1;
    random_in = w;
    @(negedge clk);
    while (!o_rready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_rready) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      for (int i = 0; i < NC; i++) begin
        c = w[i*CB +: CB];
        if (c < q[CB-1:0]) begin
          if (pushed < n_exp) begin
            sb.push_back(c);
            pushed++;
          end
        end else begin
          exp_rej++;
        end
      end
    end
    @(posedge clk);
    #1;
    random_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    int d0;
    t = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
    idle(3);
    @(negedge clk);
    check("done_pulse", 64'(done_cnt - d0), 64'd1);
    check("emitted", 64'(emitted), 64'(n_exp));
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_rdy", 64'(o_rready), 64'd0);
    check("rej_cnt", 64'(o_rej), 64'(rej_exp()));
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sel = 1'b0;
    random_valid = 1'b0;
    out_ready = 1'b1;
    q = 16'd3329;
    random_in = '0;
    n_exp = 256;
    pushed = 0;
    emitted = 0;
    done_cnt = 0;
    exp_rej = 0;
    valid_seen = 1'b0;
    last_mask = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_rdy", 64'(o_rready), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_mask", 64'(o_mask), 64'd0);
    check("rst_coef", 64'(o_coeffs), 64'd0);
    check("rst_rej", 64'(o_rej), 64'd0);
    idle(1);

    // all-zero candidates
    start_poly(16'd3329);
    repeat (16) send_word(mk_word(0));
    wait_done();
    check("zero_last_mask", 64'(last_mask), 64'hF);

    // alternating accept / reject
    start_poly(16'd3329);
    repeat (32) send_word(mk_word(1));
    wait_done();

    // everything rejected: no output, stays sampling
    start_poly(16'd3329);
    valid_seen = 1'b0;
    repeat (10) send_word(mk_word(2));
    idle(5);
    @(negedge clk);
    check("rej_no_valid", 64'(valid_seen), 64'd0);
    check("rej_busy", 64'(o_busy), 64'd1);
    check("rej_rdy", 64'(o_rready), 64'd1);
    check("rej_160", 64'(o_rej), 64'(rej_exp()));
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("rej_rst_busy", 64'(o_busy), 64'd0);
    idle(1);

    // backpressure
    out_ready = 1'b0;
    start_poly(16'd3329);
    send_word(mk_word(3));
    send_word(mk_word(3));
    @(negedge clk);
    check("bp_rdy", 64'(o_rready), 64'd0);
    idle(4);
    @(negedge clk);
    check("bp_rdy_hold", 64'(o_rready), 64'd0);
    check("bp_valid", 64'(o_valid), 64'd1);
    check("bp_mask", 64'(o_mask), 64'hF);
    idle(1);
    out_ready = 1'b1;
    repeat (14) send_word(mk_word(3));
    wait_done();

    // overshoot with mixed accept/reject words
    start_poly(16'd3329);
    while (pushed < n_exp) send_word(mk_word(4));
    wait_done();

    // short polynomial: partial final beat
    sel = 1'b1;
    n_exp = 250;
    idle(1);
    start_poly(16'd3329);
    repeat (16) send_word(mk_word(3));
    wait_done();
    check("n250_last_mask", 64'(last_mask), 64'h3);
    sel = 1'b0;
    n_exp = 256;
    idle(1);

    // reset with entries buffered, then a clean run
    out_ready = 1'b0;
    start_poly(16'd3329);
    send_word(mk_word(5));
    idle(3);
    @(negedge clk);
    check("pre_rst_valid", 64'(o_valid), 64'd1);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(o_valid), 64'd0);
    check("post_rst_busy", 64'(o_busy), 64'd0);
    idle(1);
    out_ready = 1'b1;
    start_poly(16'd3329);
    repeat (16) send_word(mk_word(3));
    wait_done();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
